// File: rtl/unidade_busca.sv
// Instruction-fetch front end.
// Holds the PC, reads one instruction word per cycle from a combinational
// instruction memory while buffer space exists, and queues {pc, word} pairs
// in a small FIFO toward decode (valid/ready handshake). Handles branch
// redirect (flush), end-of-program halt and misaligned-target halt.
//
// Ports:
//   clk              single clock, rising edge
//   reset            synchronous, active-high
//   endereco         byte address to instruction memory (the PC register)
//   instrucao        word returned by memory for endereco, same cycle
//   desvio_valido    one-cycle redirect request
//   desvio_alvo      redirect target byte address
//   saida_valida     FIFO head valid toward decode
//   saida_pronto     decode accepts the head this cycle
//   saida_instrucao  head instruction (0 when not valid)
//   saida_pc         head instruction byte address (0 when not valid)
//   fim_programa     sticky: PC ran past the last valid word
//   erro_alinhamento sticky: redirect target was not word aligned
//   ocupacao         current FIFO entry count
module unidade_busca #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_WORDS = 15,
  parameter int unsigned PROF_FILA = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic [31:0]                endereco,
  input  logic [31:0]                instrucao,
  input  logic                       desvio_valido,
  input  logic [31:0]                desvio_alvo,
  output logic                       saida_valida,
  input  logic                       saida_pronto,
  output logic [31:0]                saida_instrucao,
  output logic [31:0]                saida_pc,
  output logic                       fim_programa,
  output logic                       erro_alinhamento,
  output logic [$clog2(PROF_FILA):0] ocupacao
);

  localparam int unsigned PW = $clog2(PROF_FILA);
  localparam int unsigned OW = PW + 1;
  localparam logic [31:0] PC_LIMITE = 32'(4 * MEM_WORDS);
  localparam logic [OW-1:0] OCUP_MAX = OW'(PROF_FILA);

  logic [31:0]   pc_q, pc_d;
  logic          fim_q, fim_d;
  logic          erro_q, erro_d;
  logic [OW-1:0] ocup_q, ocup_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [PW-1:0] wr_q, wr_d;

  logic [31:0] fila_instr [PROF_FILA];
  logic [31:0] fila_pc    [PROF_FILA];

  logic em_faixa;
  logic parado;
  logic push;
  logic pop;

  assign em_faixa = (pc_q < PC_LIMITE);
  assign parado   = fim_q | erro_q;

  // A redirect cycle hides the head so decode never sees a transfer there.
  assign saida_valida = (ocup_q != '0) & ~desvio_valido;
  assign pop          = saida_valida & saida_pronto;
  // A full FIFO still accepts a write when the head leaves the same cycle.
  assign push = ~desvio_valido & ~parado & em_faixa & ((ocup_q != OCUP_MAX) | pop);

  assign endereco         = pc_q;
  assign fim_programa     = fim_q;
  assign erro_alinhamento = erro_q;
  assign ocupacao         = ocup_q;
  assign saida_instrucao  = saida_valida ? fila_instr[rd_q] : '0;
  assign saida_pc         = saida_valida ? fila_pc[rd_q] : '0;

  always_comb begin
    pc_d   = pc_q;
    fim_d  = fim_q;
    erro_d = erro_q;
    ocup_d = ocup_q;
    rd_d   = rd_q;
    wr_d   = wr_q;
    if (desvio_valido) begin
      ocup_d = '0;
      rd_d   = '0;
      wr_d   = '0;
      fim_d  = 1'b0;
      if (desvio_alvo[1:0] == 2'b00) begin
        pc_d = desvio_alvo;
      end else begin
        erro_d = 1'b1;
      end
    end else begin
      if (push) begin
        wr_d = wr_q + PW'(1);
        pc_d = pc_q + 32'd4;
      end
      if (pop) begin
        rd_d = rd_q + PW'(1);
      end
      ocup_d = ocup_q + OW'(push) - OW'(pop);
      if (!em_faixa && !parado) begin
        fim_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q   <= RESET_PC;
      fim_q  <= 1'b0;
      erro_q <= 1'b0;
      ocup_q <= '0;
      rd_q   <= '0;
      wr_q   <= '0;
    end else begin
      pc_q   <= pc_d;
      fim_q  <= fim_d;
      erro_q <= erro_d;
      ocup_q <= ocup_d;
      rd_q   <= rd_d;
      wr_q   <= wr_d;
    end
  end

  // Storage needs no reset: entries are only read while counted in ocup_q.
  always_ff @(posedge clk) begin
    if (push) begin
      fila_instr[wr_q] <= instrucao;
      fila_pc[wr_q]    <= pc_q;
    end
  end

endmodule

// File: tb/tb_unidade_busca.sv
// Self-checking bench for unidade_busca: directed table, hand sequences for
// end-of-program / redirect / mid-run reset, and randomized stimulus against
// a queue-based reference model.
module tb_unidade_busca;

  localparam int unsigned MW = 15;
  localparam int unsigned PF = 2;
  localparam logic [31:0] RPC = 32'h0;
  localparam logic [31:0] LIMITE = 32'(4 * MW);

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        dv = 1'b0;
  logic        pr = 1'b0;
  logic [31:0] alvo = '0;
  logic [31:0] endereco, instrucao, spc, sinstr;
  logic        sval, fim, erro;
  logic [1:0]  ocup;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  // Memory image: word k holds k+100.
  assign instrucao = (endereco >> 2) + 32'd100;

  unidade_busca #(
    .RESET_PC (RPC),
    .MEM_WORDS(MW),
    .PROF_FILA(PF)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .endereco        (endereco),
    .instrucao       (instrucao),
    .desvio_valido   (dv),
    .desvio_alvo     (alvo),
    .saida_valida    (sval),
    .saida_pronto    (pr),
    .saida_instrucao (sinstr),
    .saida_pc        (spc),
    .fim_programa    (fim),
    .erro_alinhamento(erro),
    .ocupacao        (ocup)
  );

  typedef struct {
    logic        r;
    logic        d;
    logic [31:0] a;
    logic        p;
    logic        ev;
    logic [31:0] epc;
    int          eoc;
    logic [31:0] eend;
    logic        efim;
    logic        eerr;
  } vec_t;

  vec_t tbl[19];

  // Reference model state
  logic [31:0] m_pc;
  logic        m_fim, m_err;
  logic [31:0] m_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Apply inputs away from the active edge, let combinational outputs settle.
  task automatic drive(input logic r, input logic d, input logic [31:0] a, input logic p);
    @(negedge clk);
    reset = r;
    dv    = d;
    alvo  = a;
    pr    = p;
    #1;
  endtask

  task automatic expect_all(input string tag, input logic ev, input logic [31:0] epc,
                            input int eoc, input logic [31:0] eend, input logic efim,
                            input logic eerr);
    chk({tag, ".valida"}, 32'(sval), 32'(ev));
    chk({tag, ".pc"}, spc, ev ? epc : 32'h0);
    chk({tag, ".instr"}, sinstr, ev ? (epc / 4) + 32'd100 : 32'h0);
    chk({tag, ".ocup"}, 32'(ocup), 32'(eoc));
    chk({tag, ".endereco"}, endereco, eend);
    chk({tag, ".fim"}, 32'(fim), 32'(efim));
    chk({tag, ".erro"}, 32'(erro), 32'(eerr));
  endtask

  // Advance the model by one clock edge given this cycle's inputs.
  task automatic model_step(input logic r, input logic d, input logic [31:0] a, input logic p);
    if (r) begin
      m_q.delete();
      m_pc  = RPC;
      m_fim = 1'b0;
      m_err = 1'b0;
    end else if (d) begin
      m_q.delete();
      m_fim = 1'b0;
      if (a % 4 == 0) m_pc = a;
      else m_err = 1'b1;
    end else begin
      if (m_q.size() > 0 && p) void'(m_q.pop_front());
      if (!m_fim && !m_err) begin
        if (m_pc >= LIMITE) begin
          m_fim = 1'b1;
        end else if (m_q.size() < PF) begin
          m_q.push_back(m_pc);
          m_pc = m_pc + 32'd4;
        end
      end
    end
  endtask

  initial begin
    tbl[0]  = '{1'b0, 1'b0, 32'd0,  1'b0, 1'b0, 32'd0,  0, 32'd0,  1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 32'd0,  1'b0, 1'b1, 32'd0,  1, 32'd4,  1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 32'd0,  1'b0, 1'b1, 32'd0,  2, 32'd8,  1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 32'd0,  1'b0, 1'b1, 32'd0,  2, 32'd8,  1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 32'd0,  1'b1, 1'b1, 32'd0,  2, 32'd8,  1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 32'd0,  1'b1, 1'b1, 32'd4,  2, 32'd12, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 32'd0,  1'b0, 1'b1, 32'd8,  2, 32'd16, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 32'd32, 1'b1, 1'b0, 32'd0,  2, 32'd16, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 32'd0,  1'b0, 1'b0, 32'd0,  0, 32'd32, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 32'd0,  1'b1, 1'b1, 32'd32, 1, 32'd36, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 32'd0,  1'b0, 1'b1, 32'd36, 1, 32'd40, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 32'd6,  1'b0, 1'b0, 32'd0,  2, 32'd44, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 32'd0,  1'b1, 1'b0, 32'd0,  0, 32'd44, 1'b0, 1'b1};
    tbl[13] = '{1'b0, 1'b0, 32'd0,  1'b1, 1'b0, 32'd0,  0, 32'd44, 1'b0, 1'b1};
    tbl[14] = '{1'b0, 1'b1, 32'd0,  1'b1, 1'b0, 32'd0,  0, 32'd44, 1'b0, 1'b1};
    tbl[15] = '{1'b0, 1'b0, 32'd0,  1'b1, 1'b0, 32'd0,  0, 32'd0,  1'b0, 1'b1};
    tbl[16] = '{1'b1, 1'b0, 32'd0,  1'b1, 1'b0, 32'd0,  0, 32'd0,  1'b0, 1'b1};
    tbl[17] = '{1'b0, 1'b0, 32'd0,  1'b1, 1'b0, 32'd0,  0, 32'd0,  1'b0, 1'b0};
    tbl[18] = '{1'b0, 1'b0, 32'd0,  1'b1, 1'b1, 32'd0,  1, 32'd4,  1'b0, 1'b0};

    // Backpressure, redirect, misaligned halt, reset clearing the flag.
    drive(1'b1, 1'b0, 32'd0, 1'b0);
    for (int i = 0; i < 19; i++) begin
      drive(tbl[i].r, tbl[i].d, tbl[i].a, tbl[i].p);
      expect_all($sformatf("tbl%0d", i), tbl[i].ev, tbl[i].epc, tbl[i].eoc, tbl[i].eend,
                 tbl[i].efim, tbl[i].eerr);
    end

    // Full program run with decode always ready, then restart via redirect.
    drive(1'b1, 1'b0, 32'd0, 1'b1);
    drive(1'b0, 1'b0, 32'd0, 1'b1);
    expect_all("run.c0", 1'b0, 32'd0, 0, 32'd0, 1'b0, 1'b0);
    for (int c = 1; c <= 15; c++) begin
      drive(1'b0, 1'b0, 32'd0, 1'b1);
      expect_all($sformatf("run.c%0d", c), 1'b1, 32'(4 * (c - 1)), 1, 32'(4 * c), 1'b0, 1'b0);
    end
    drive(1'b0, 1'b1, 32'd0, 1'b1);
    expect_all("run.end", 1'b0, 32'd0, 0, 32'd60, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 32'd0, 1'b1);
    expect_all("run.redir", 1'b0, 32'd0, 0, 32'd0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 32'd0, 1'b1);
    expect_all("run.resume", 1'b1, 32'd0, 1, 32'd4, 1'b0, 1'b0);

    // Reset with two entries queued and pc=20.
    drive(1'b1, 1'b0, 32'd0, 1'b0);
    for (int c = 0; c < 4; c++) drive(1'b0, 1'b0, 32'd0, 1'b1);
    drive(1'b0, 1'b0, 32'd0, 1'b0);
    drive(1'b1, 1'b0, 32'd0, 1'b0);
    expect_all("rst.before", 1'b1, 32'd12, 2, 32'd20, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 32'd0, 1'b1);
    expect_all("rst.after", 1'b0, 32'd0, 0, 32'd0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 32'd0, 1'b1);
    expect_all("rst.restart", 1'b1, 32'd0, 1, 32'd4, 1'b0, 1'b0);

    // Randomized run against the reference model.
    drive(1'b1, 1'b0, 32'd0, 1'b0);
    model_step(1'b1, 1'b0, 32'd0, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      logic        r, d, p, ev;
      logic [31:0] a, epc;
      int unsigned sel;
      r   = ($urandom_range(0, 63) == 0);
      d   = ($urandom_range(0, 11) == 0);
      sel = $urandom_range(0, 9);
      a   = 32'($urandom_range(0, 20) * 4) + ((sel == 0) ? 32'd2 : 32'd0);
      p   = ($urandom_range(0, 3) != 0);
      drive(r, d, a, p);
      ev  = (m_q.size() != 0) && !d;
      epc = ev ? m_q[0] : 32'h0;
      expect_all($sformatf("rnd%0d", i), ev, epc, m_q.size(), m_pc, m_fim, m_err);
      model_step(r, d, a, p);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
